// File: rtl/rca_pkg.sv
// Shared definitions for the sequential slice-adder controller.
// The package holds the FSM encoding, the slice width and a carry helper used by the slice adder.
package rca_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Majority function: carry-out of a single full-adder bit.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder slice; purely combinational.
module rca_16b
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin_i;

  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
      assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi + 1] = fa_carry(a_i[gi], b_i[gi], carry[gi]);
    end
  endgenerate

  assign cout_o = carry[SLICE_W];

endmodule

// File: rtl/rca_80b_seq_ctrl.sv
// 80-bit A+B+Cin computed over NSLICE cycles by one shared rca_16b, LSB slice first.
// Valid/ready handshake on both the operand and the result side.
module rca_80b_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 80,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  s_q;
  logic [WIDTH-1:0]  s_d;
  logic              cout_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [SLICE-1:0]  a_slice [NSLICE];
  logic [SLICE-1:0]  b_slice [NSLICE];
  logic [SLICE-1:0]  a_cur;
  logic [SLICE-1:0]  b_cur;
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;
  logic              accept;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slice[gi] = a_q[gi*SLICE +: SLICE];
      assign b_slice[gi] = b_q[gi*SLICE +: SLICE];
    end
  endgenerate

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_cur = a_slice[i];
        b_cur = b_slice[i];
      end
    end
  end

  rca_16b u_slice_adder (
    .a_i    (a_cur),
    .b_i    (b_cur),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Write the freshly computed slice back into its position of the sum register.
  always_comb begin
    s_d = s_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        s_d[i*SLICE +: SLICE] = slice_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q         <= A;
            b_q         <= B;
            carry_q     <= Cin;
            idx_q       <= '0;
            s_q         <= '0;
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        ST_RUN: begin
          s_q     <= s_d;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_cout;
            idx_q       <= '0;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          // An accept here implies out_ready, so the result is taken in the same cycle.
          if (accept) begin
            a_q         <= A;
            b_q         <= B;
            carry_q     <= Cin;
            idx_q       <= '0;
            s_q         <= '0;
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end else if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= '0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rca_80b_seq_ctrl.sv
// Directed bench for rca_80b_seq_ctrl: ripple, latency, back-to-back, backpressure, reset abort.
module tb_rca_80b_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] a_in;
  logic [79:0] b_in;
  logic        cin_in;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] s_out;
  logic        cout_out;
  logic        busy;

  int vec_cnt;
  int miscmp_cnt;

  rca_80b_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .Cin       (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s_out),
    .Cout      (cout_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [80:0] gold(input logic [79:0] a, input logic [79:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {80'd0, c};
  endfunction

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  // Present one operand set, wait for the result, take it; lat counts edges from accept to out_valid.
  task automatic run_add(input logic [79:0] a, input logic [79:0] b, input logic c,
                         output logic [79:0] s, output logic co, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    a_in = a; b_in = b; cin_in = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    s  = s_out;
    co = cout_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [79:0] s_got;
  logic        co_got;
  int          lat;
  logic [79:0] pa [3];
  logic [79:0] pb [3];
  logic        pc [3];
  logic [80:0] pexp [3];
  logic [80:0] g;
  logic [79:0] hold_s;
  logic        hold_c;
  logic        acc;
  logic        take;
  int          issued;
  int          got_n;

  initial begin
    vec_cnt = 0; miscmp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    tick(); tick();
    check_val("rst_s", s_out, 0);
    check_val("rst_cout", cout_out, 0);
    check_val("rst_ov", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_inrdy", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Full carry ripple through all five slices.
    run_add(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h0, 1'b1, s_got, co_got, lat);
    check_val("t1_s", s_got, 0);
    check_val("t1_cout", co_got, 1);
    check_val("t1_lat", lat, 5);
    check_val("t1_idle", in_ready, 1);

    run_add(80'h0000_0000_0001_0000_FFFF, 80'h0000_0000_0000_0000_0001, 1'b0, s_got, co_got, lat);
    check_val("t2_s", s_got, 80'h0000_0000_0001_0001_0000);
    check_val("t2_cout", co_got, 0);
    check_val("t2_lat", lat, 5);

    // Back-to-back with both handshakes held high.
    for (int i = 0; i < 3; i++) begin
      pa[i] = rand80(); pb[i] = rand80(); pc[i] = 1'($urandom_range(1));
      pexp[i] = gold(pa[i], pb[i], pc[i]);
    end
    pa[2] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    pexp[2] = gold(pa[2], pb[2], pc[2]);
    issued = 0; got_n = 0;
    a_in = pa[0]; b_in = pb[0]; cin_in = pc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got_n < 3; cyc++) begin
      acc  = in_ready & in_valid;
      take = out_valid & out_ready;
      if (take) begin
        check_val("t3_s", s_out, pexp[got_n][79:0]);
        check_val("t3_cout", cout_out, pexp[got_n][80]);
        if (got_n < 2) check_val("t3_overlap", acc, 1);
        got_n++;
      end
      tick();
      if (acc) begin
        issued++;
        if (issued < 3) begin
          a_in = pa[issued]; b_in = pb[issued]; cin_in = pc[issued];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check_val("t3_count", got_n, 3);
    check_val("t3_issued", issued, 3);
    out_ready = 1'b0;
    tick(); tick();
    check_val("t3_no_dup", out_valid, 0);

    // Backpressure in DONE.
    g = gold(80'h1234_5678_9ABC_DEF0_1357, 80'hFEDC_BA98_7654_3210_ECA9, 1'b1);
    a_in = 80'h1234_5678_9ABC_DEF0_1357; b_in = 80'hFEDC_BA98_7654_3210_ECA9; cin_in = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check_val("t4_lat", lat, 5);
    hold_s = s_out; hold_c = cout_out;
    check_val("t4_s", hold_s, g[79:0]);
    check_val("t4_cout", hold_c, g[80]);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a_in = rand80();
      check_val("t4_hold_s", s_out, g[79:0]);
      check_val("t4_inrdy", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check_val("t4_ov_held", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t4_ov_after", out_valid, 0);
    check_val("t4_idle", in_ready, 1);
    tick(); tick();
    check_val("t4_single", out_valid, 0);

    // Reset while idx==2.
    a_in = 80'hFFFF_FFFF_FFFF_FFFF_FFFF; b_in = 80'h1; cin_in = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_val("t5_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("t5_s", s_out, 0);
    check_val("t5_cout", cout_out, 0);
    check_val("t5_ov", out_valid, 0);
    check_val("t5_busy0", busy, 0);
    check_val("t5_inrdy", in_ready, 1);
    run_add(80'h1, 80'h1, 1'b0, s_got, co_got, lat);
    check_val("t5_add_s", s_got, 2);
    check_val("t5_add_cout", co_got, 0);
    check_val("t5_add_lat", lat, 5);

    // in_valid pulsed with changing A during RUN.
    g = gold(80'h8000_0000_0000_0000_0001, 80'h8000_0000_0000_0000_FFFF, 1'b0);
    a_in = 80'h8000_0000_0000_0000_0001; b_in = 80'h8000_0000_0000_0000_FFFF; cin_in = 1'b0;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      a_in = rand80(); b_in = rand80(); cin_in = 1'b1;
      check_val("t6_inrdy", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check_val("t6_lat", lat, 1);
    check_val("t6_s", s_out, g[79:0]);
    check_val("t6_cout", cout_out, g[80]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t6_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
